// File: rtl/pingpong_wr_ctrl_if.sv
// Write-port bundle between the acquisition front end, the write sequencer
// and the 2x128x8 ping-pong buffer.
interface pingpong_wr_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
) ();
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              readya;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              finisha;

    modport master (
        input  din, din_valid, readya,
        output wea, addra, dina, finisha
    );

    modport slave (
        output din, din_valid, readya,
        input  wea, addra, dina, finisha
    );
endinterface

// File: rtl/pingpong_wr_ctrl.sv
// Write-side sequencer for the ping-pong sample buffer: fills one half per frame,
// optionally gated by a rising trigger crossing, and counts frames and drops.
module pingpong_wr_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               trig_mode,
    input  logic [DATA_W-1:0]  trig_level,
    pingpong_wr_ctrl_if.master buf_if,
    output logic               busy,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TRIG = 3'd1,
        FILL      = 3'd2,
        FINISH    = 3'd3,
        HOLD      = 3'd4,
        WAIT_RDY  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    function automatic logic rising_cross(input logic [DATA_W-1:0] prev,
                                          input logic [DATA_W-1:0] cur,
                                          input logic [DATA_W-1:0] lvl);
        return (prev < lvl) && (cur >= lvl);
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] wr_cnt_r;
    logic [ADDR_W-1:0] wr_cnt_nxt_s;
    logic [DATA_W-1:0] prev_r;
    logic              wea_r;
    logic [ADDR_W-1:0] addra_r;
    logic [DATA_W-1:0] dina_r;
    logic              finisha_r;
    logic              busy_r;
    logic [CNT_W-1:0]  frame_cnt_r;
    logic [CNT_W-1:0]  drop_cnt_r;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              finish_s;
    logic              drop_s;
    logic              trig_hit_s;
    logic              free_resume_s;

    assign trig_hit_s    = buf_if.din_valid && rising_cross(prev_r, buf_if.din, trig_level);
    // Free-run restart writes the sample arriving on the WAIT_RDY exit edge.
    assign free_resume_s = buf_if.readya && arm && !trig_mode && buf_if.din_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (arm && buf_if.readya) begin
                    state_nxt_s = trig_mode ? WAIT_TRIG : FILL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_TRIG: begin
                if (trig_hit_s) begin
                    state_nxt_s = FILL;
                end else if (!arm) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_TRIG;
                end
            end
            FILL: begin
                if (buf_if.din_valid && (wr_cnt_r == ADDR_LAST)) begin
                    state_nxt_s = FINISH;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            FINISH:   state_nxt_s = HOLD;
            HOLD:     state_nxt_s = WAIT_RDY;
            WAIT_RDY: begin
                if (!buf_if.readya) begin
                    state_nxt_s = WAIT_RDY;
                end else if (!arm) begin
                    state_nxt_s = IDLE;
                end else if (trig_mode) begin
                    state_nxt_s = WAIT_TRIG;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            default:  state_nxt_s = IDLE;
        endcase
    end

    // Write, finish and drop decode for the coming edge.
    always_comb begin
        wr_en_s      = 1'b0;
        wr_addr_s    = addra_r;
        wr_data_s    = dina_r;
        finish_s     = 1'b0;
        drop_s       = 1'b0;
        wr_cnt_nxt_s = wr_cnt_r;
        case (state_r)
            WAIT_TRIG: begin
                if (trig_hit_s) begin
                    wr_en_s      = 1'b1;
                    wr_addr_s    = ADDR_ZERO;
                    wr_data_s    = buf_if.din;
                    wr_cnt_nxt_s = ADDR_ONE;
                end else begin
                    wr_cnt_nxt_s = ADDR_ZERO;
                end
            end
            FILL: begin
                if (buf_if.din_valid) begin
                    wr_en_s      = 1'b1;
                    wr_addr_s    = wr_cnt_r;
                    wr_data_s    = buf_if.din;
                    wr_cnt_nxt_s = wr_cnt_r + ADDR_ONE;
                end else begin
                    wr_cnt_nxt_s = wr_cnt_r;
                end
            end
            FINISH: begin
                finish_s     = 1'b1;
                wr_cnt_nxt_s = ADDR_ZERO;
                drop_s       = buf_if.din_valid && arm;
            end
            HOLD: begin
                drop_s = buf_if.din_valid && arm;
            end
            WAIT_RDY: begin
                if (free_resume_s) begin
                    wr_en_s      = 1'b1;
                    wr_addr_s    = ADDR_ZERO;
                    wr_data_s    = buf_if.din;
                    wr_cnt_nxt_s = ADDR_ONE;
                end else begin
                    drop_s = buf_if.din_valid && arm;
                end
            end
            default: begin
                wr_cnt_nxt_s = ADDR_ZERO;
            end
        endcase
    end

    // Registered outputs, write counter, trigger history and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_r    <= ADDR_ZERO;
            prev_r      <= {DATA_W{1'b0}};
            wea_r       <= 1'b0;
            addra_r     <= ADDR_ZERO;
            dina_r      <= {DATA_W{1'b0}};
            finisha_r   <= 1'b0;
            busy_r      <= 1'b0;
            frame_cnt_r <= CNT_ZERO;
            drop_cnt_r  <= CNT_ZERO;
        end else begin
            wr_cnt_r  <= wr_cnt_nxt_s;
            wea_r     <= wr_en_s;
            addra_r   <= wr_addr_s;
            dina_r    <= wr_data_s;
            finisha_r <= finish_s;
            busy_r    <= (state_nxt_s != IDLE);
            if (buf_if.din_valid) begin
                prev_r <= buf_if.din;
            end else begin
                prev_r <= prev_r;
            end
            if (finish_s) begin
                frame_cnt_r <= frame_cnt_r + CNT_ONE;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
            if (drop_s && (drop_cnt_r != CNT_MAX)) begin
                drop_cnt_r <= drop_cnt_r + CNT_ONE;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign buf_if.wea     = wea_r;
    assign buf_if.addra   = addra_r;
    assign buf_if.dina    = dina_r;
    assign buf_if.finisha = finisha_r;
    assign busy           = busy_r;
    assign frame_cnt      = frame_cnt_r;
    assign drop_cnt       = drop_cnt_r;
endmodule

// File: doc/pingpong_wr_ctrl.md
Name: pingpong_wr_ctrl

Overview:
- Write-side sequencer for the 2x128x8 ping-pong sample buffer.
- Takes a valid-qualified 8-bit sample stream from the acquisition front end and produces the buffer's write-port signals: write enable, address, data and the end-of-frame pulse.
- Fills one 128-sample half per frame, then holds off until the buffer reports the next half is free.
- Frames start either immediately (free-run) or on a rising level crossing (trigger mode).
- Counts completed frames and samples dropped while stalled.

Parameters:
- DATA_W, 8, sample width.
- ADDR_W, 7, address width; frame length is 2^ADDR_W = 128.
- CNT_W, 16, width of the frame and drop counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  level; 1 = keep capturing frames, 0 = stop after the current frame.
- trig_mode  in  1  0 = free-run, 1 = each frame waits for a trigger crossing.
- trig_level  in  DATA_W  unsigned trigger threshold.
- din  in  DATA_W  sample.
- din_valid  in  1  sample strobe, at most one sample per cycle.
- readya  in  1  buffer write-half-free flag.
- wea  out  1  buffer write enable.
- addra  out  ADDR_W  buffer write address.
- dina  out  DATA_W  buffer write data.
- finisha  out  1  one-cycle end-of-frame pulse to the buffer.
- busy  out  1  1 whenever the FSM is not in IDLE.
- frame_cnt  out  CNT_W  number of completed frames, wraps.
- drop_cnt  out  CNT_W  number of dropped samples, saturates at all-ones.

Behaviour:
- Reset state:
  - FSM = IDLE; wea=0, addra=0, dina=0, finisha=0, busy=0.
  - frame_cnt=0, drop_cnt=0; previous-sample register = 0.
  - Reset mid-frame abandons the partial frame; finisha is not issued.
- All outputs are registered.
- A write issued from sample k appears on wea/addra/dina exactly 1 cycle after that sample's din_valid cycle.
- FSM states: IDLE, WAIT_TRIG, FILL, FINISH, HOLD, WAIT_RDY.
- IDLE:
  - Leave only when arm=1 and readya=1.
  - Go to WAIT_TRIG if trig_mode=1, else FILL.
  - trig_mode is sampled at this transition and at each WAIT_RDY exit.
- WAIT_TRIG:
  - Trigger = din_valid and prev < trig_level and din >= trig_level (unsigned). prev is the last valid sample, updated on every din_valid in every state.
  - The trigger sample itself is written at address 0; go to FILL with the write counter at 1.
  - Non-trigger samples here are discarded and are not counted as drops.
  - arm=0 in this state -> IDLE.
- FILL:
  - Each din_valid writes din at address = write counter, then the counter increments.
  - Gaps in din_valid are tolerated; arm is ignored mid-frame.
  - When address 127 is written, go to FINISH.
- FINISH: finisha=1 for exactly this one cycle; frame_cnt increments; counter resets to 0.
- HOLD: one cycle with readya ignored, because the buffer drops readya one cycle after finisha.
- WAIT_RDY:
  - Stay until readya=1.
  - On exit: arm=0 -> IDLE; else trig_mode=1 -> WAIT_TRIG; else FILL.
- Drops:
  - din_valid in FINISH, HOLD or WAIT_RDY with arm=1 increments drop_cnt (saturating).
  - In free-run the first sample after the WAIT_RDY exit is written, not dropped.
- Invariants: wea and finisha are never high in the same cycle; wea=0 outside FILL and the trigger write.
- Simultaneous events:
  - Trigger on the last sample before arm falls in WAIT_TRIG: the trigger wins and the frame completes.
  - readya=1 on HOLD's cycle is ignored.

Test Plan:
- Free-run: arm=1, trig_mode=0, readya=1, din_valid every cycle with din = 0,1,2,… → wea on 128 consecutive cycles, addra 0..127, dina=addra; finisha 1 cycle after the addra=127 write; frame_cnt=1.
- Back-pressure: after finisha, hold readya=0 for 20 cycles with din_valid continuous → no wea during the stall; drop_cnt=22 (FINISH+HOLD+20); the next frame starts at addra=0 once readya=1.
- Trigger: trig_mode=1, trig_level=0x80, ramp 0x70..0x90 step 1 → first write has dina=0x80 at addra=0; samples 0x70..0x7F are not written and not counted as drops.
- Disarm: arm falls at addra=50 → frame completes to 127, finisha pulses, FSM reaches IDLE, busy=0 after WAIT_RDY; no further writes.
- Sparse input: din_valid every 3rd cycle → addra advances only on valid samples; finisha is still 1 cycle after the 128th write.
- Reset at addra=64 → all outputs return to reset values the next cycle; no finisha; frame_cnt=0.
